// File: rtl/upe_edge_lanes.sv
// upe_edge_lanes: multi-lane unary edge PE, accumulates a signed product count over a window, adds the upstream psum, outputs via valid/ready
// Ports: weight load (w_*), streamed input (i_*), random-number chain (*_rand_in/out),
// forwarded unary input (u_i_*), window control (start, stream_len, busy),
// upstream psum (psum_in*), result handshake (psum_out*).
// Define UPE_SAT_EN to make every accumulator update saturate instead of wrapping.
module upe_edge_lanes #(
  parameter int W_BW   = 8,
  parameter int I_BW   = 8,
  parameter int RN_BW  = 7,
  parameter int LANES  = 2,
  parameter int O_BW   = 16,
  parameter int LEN_BW = 10
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   w_load,
  input  logic [W_BW-2:0]        w_abs,
  input  logic                   w_sign,
  input  logic                   i_valid,
  input  logic [I_BW-2:0]        i_abs,
  input  logic                   i_sign,
  input  logic                   rand_en,
  input  logic [LANES*RN_BW-1:0] w_rand_in,
  input  logic [LANES*RN_BW-1:0] i_rand_in,
  output logic [LANES*RN_BW-1:0] w_rand_out,
  output logic [LANES*RN_BW-1:0] i_rand_out,
  output logic [LANES-1:0]       u_i_out,
  output logic                   u_i_sign_out,
  output logic                   u_i_valid_out,
  input  logic                   start,
  input  logic [LEN_BW-1:0]      stream_len,
  input  logic [O_BW-1:0]        psum_in,
  input  logic                   psum_in_valid,
  output logic [O_BW-1:0]        psum_out,
  output logic                   psum_out_valid,
  input  logic                   psum_out_ready,
  output logic                   busy
);
  typedef enum logic [1:0] {IDLE, COMPUTE, MERGE, OUT} state_t;
  state_t state, state_nx;
  logic [W_BW-2:0]   w_abs_reg;
  logic              w_sign_reg;
  logic [LEN_BW-1:0] cnt;
  logic [O_BW-1:0]   acc, pop, delta, merged;
  logic [LANES-1:0]  u_w, u_i;

  function automatic logic [O_BW-1:0] acc_add(input logic [O_BW-1:0] a, input logic [O_BW-1:0] b);
`ifdef UPE_SAT_EN
    logic [O_BW:0] s;
    s = {a[O_BW-1], a} + {b[O_BW-1], b};
    return (s[O_BW] != s[O_BW-1]) ? {s[O_BW], {(O_BW-1){~s[O_BW]}}} : s[O_BW-1:0];
`else
    return a + b;
`endif
  endfunction

  always_comb begin
    pop = '0;
    for (int l = 0; l < LANES; l++) begin
      u_w[l] = RN_BW'(w_abs_reg) > w_rand_out[l*RN_BW +: RN_BW];
      u_i[l] = RN_BW'(i_abs) > i_rand_out[l*RN_BW +: RN_BW];
      pop = pop + O_BW'(u_w[l] & u_i[l]);
    end
    delta = (i_sign ^ w_sign_reg) ? -pop : pop;
    merged = acc_add(acc, psum_in);
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = start ? ((stream_len != '0) ? COMPUTE : MERGE) : IDLE;
      COMPUTE: state_nx = (i_valid && cnt == LEN_BW'(1)) ? MERGE : COMPUTE;
      MERGE:   state_nx = psum_in_valid ? OUT : MERGE;
      OUT:     state_nx = psum_out_ready ? IDLE : OUT;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = state != IDLE;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      w_abs_reg      <= '0;
      w_sign_reg     <= 1'b0;
      w_rand_out     <= '0;
      i_rand_out     <= '0;
      u_i_out        <= '0;
      u_i_sign_out   <= 1'b0;
      u_i_valid_out  <= 1'b0;
      cnt            <= '0;
      acc            <= '0;
      psum_out       <= '0;
      psum_out_valid <= 1'b0;
    end else begin
      state         <= state_nx;
      u_i_out       <= u_i;
      u_i_sign_out  <= i_sign;
      u_i_valid_out <= i_valid;
      if (rand_en) begin
        w_rand_out <= w_rand_in;
        i_rand_out <= i_rand_in;
      end
      if (state == IDLE && w_load) begin
        w_abs_reg  <= w_abs;
        w_sign_reg <= w_sign;
      end
      unique case (state)
        IDLE: if (start) begin
          acc <= '0;
          cnt <= stream_len;
        end
        COMPUTE: if (i_valid) begin
          acc <= acc_add(acc, delta);
          cnt <= cnt - 1'b1;
        end
        MERGE: if (psum_in_valid) begin
          acc            <= merged;
          psum_out       <= merged;
          psum_out_valid <= 1'b1;
        end
        OUT: if (psum_out_ready) psum_out_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_upe_edge_lanes.sv
// tb_upe_edge_lanes: scoreboard bench for upe_edge_lanes with directed windows
module tb_upe_edge_lanes;
  localparam int W_BW = 8, I_BW = 8, RN_BW = 7, LANES = 2, O_BW = 16, LEN_BW = 10;
  logic clk, resetn, w_load, w_sign, i_valid, i_sign, rand_en, start;
  logic psum_in_valid, psum_out_valid, psum_out_ready, busy, u_i_sign_out, u_i_valid_out;
  logic [W_BW-2:0] w_abs;
  logic [I_BW-2:0] i_abs;
  logic [LANES*RN_BW-1:0] w_rand_in, i_rand_in, w_rand_out, i_rand_out;
  logic [LANES-1:0] u_i_out;
  logic [LEN_BW-1:0] stream_len;
  logic [O_BW-1:0] psum_in, psum_out;
  int n_vec, n_err;
  logic [O_BW-1:0] exp_q[$];

  upe_edge_lanes #(.W_BW(W_BW), .I_BW(I_BW), .RN_BW(RN_BW), .LANES(LANES), .O_BW(O_BW), .LEN_BW(LEN_BW)) dut (
    .clk(clk), .resetn(resetn), .w_load(w_load), .w_abs(w_abs), .w_sign(w_sign),
    .i_valid(i_valid), .i_abs(i_abs), .i_sign(i_sign), .rand_en(rand_en),
    .w_rand_in(w_rand_in), .i_rand_in(i_rand_in), .w_rand_out(w_rand_out), .i_rand_out(i_rand_out),
    .u_i_out(u_i_out), .u_i_sign_out(u_i_sign_out), .u_i_valid_out(u_i_valid_out),
    .start(start), .stream_len(stream_len), .psum_in(psum_in), .psum_in_valid(psum_in_valid),
    .psum_out(psum_out), .psum_out_valid(psum_out_valid), .psum_out_ready(psum_out_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(negedge clk);
    if (resetn && psum_out_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got %0h, expected no output", psum_out);
      end else if (psum_out_ready) chk("psum_out", psum_out, exp_q.pop_front());
      else chk("psum_hold", psum_out, exp_q[0]);
    end
  end

  task automatic set_rand;
    rand_en = 1'b1;
    w_rand_in = {7'd48, 7'd48};
    i_rand_in = {7'd48, 7'd48};
    tick;
    rand_en = 1'b0;
  endtask

  task automatic run_window(input logic [6:0] wa, input logic ws, input logic [6:0] ia, input logic is,
                            input int len, input logic [15:0] pin, input logic [15:0] exp,
                            input bit gap, input int hold);
    exp_q.push_back(exp);
    w_abs = wa; w_sign = ws; w_load = 1'b1;
    i_abs = ia; i_sign = is;
    start = 1'b1; stream_len = LEN_BW'(len);
    tick;
    w_load = 1'b0; start = 1'b0;
    chk("busy_start", busy, 1);
    for (int k = 0; k < len; k++) begin
      i_valid = 1'b1;
      tick;
      i_valid = 1'b0;
      if (k == 0) begin
        chk("u_i_out", u_i_out, (ia > 7'd48) ? 2'b11 : 2'b00);
        chk("u_i_valid_out", u_i_valid_out, 1);
        chk("u_i_sign_out", u_i_sign_out, is);
      end
      if (gap && k < len - 1) begin
        start = 1'b1; stream_len = 10'd1;
        tick;
        start = 1'b0;
      end
    end
    psum_in = pin; psum_in_valid = 1'b1;
    chk("valid_pre", psum_out_valid, 0);
    tick;
    psum_in_valid = 1'b0;
    chk("valid_rise", psum_out_valid, 1);
    psum_out_ready = 1'b0;
    repeat (hold) tick;
    psum_out_ready = 1'b1;
    tick;
    psum_out_ready = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_valid", psum_out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_err = 0;
    resetn = 1'b0; w_load = 1'b0; w_abs = '0; w_sign = 1'b0; i_valid = 1'b0; i_abs = '0; i_sign = 1'b0;
    rand_en = 1'b0; w_rand_in = '0; i_rand_in = '0; start = 1'b0; stream_len = '0;
    psum_in = '0; psum_in_valid = 1'b0; psum_out_ready = 1'b0;
    repeat (2) tick;
    chk("rst_busy", busy, 0);
    chk("rst_valid", psum_out_valid, 0);
    chk("rst_psum", psum_out, 0);
    resetn = 1'b1;
    set_rand;
    run_window(7'd100, 1'b0, 7'd50, 1'b0, 4, 16'd5, 16'd13, 1'b0, 0);
    run_window(7'd100, 1'b1, 7'd50, 1'b0, 4, 16'd5, 16'hFFFD, 1'b0, 0);
    run_window(7'd100, 1'b1, 7'd50, 1'b1, 4, 16'd5, 16'd13, 1'b0, 0);
    run_window(7'd100, 1'b0, 7'd50, 1'b0, 4, 16'd0, 16'd8, 1'b1, 0);
    run_window(7'd100, 1'b0, 7'd50, 1'b0, 4, 16'd5, 16'd13, 1'b0, 3);
    run_window(7'd100, 1'b0, 7'd40, 1'b0, 3, 16'd7, 16'd7, 1'b0, 0);
    run_window(7'd100, 1'b0, 7'd50, 1'b0, 0, 16'd32760, 16'd32760, 1'b0, 0);
`ifdef UPE_SAT_EN
    run_window(7'd100, 1'b0, 7'd50, 1'b0, 4, 16'd32760, 16'h7FFF, 1'b0, 0);
    run_window(7'd100, 1'b1, 7'd50, 1'b0, 4, 16'h8003, 16'h8000, 1'b0, 0);
`else
    run_window(7'd100, 1'b0, 7'd50, 1'b0, 4, 16'd32760, 16'h8000, 1'b0, 0);
    run_window(7'd100, 1'b1, 7'd50, 1'b0, 4, 16'h8003, 16'h7FFB, 1'b0, 0);
`endif
    w_abs = 7'd100; w_sign = 1'b0; w_load = 1'b1; i_abs = 7'd50; i_sign = 1'b0;
    start = 1'b1; stream_len = 10'd4;
    tick;
    w_load = 1'b0; start = 1'b0; i_valid = 1'b1;
    repeat (2) tick;
    resetn = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", psum_out_valid, 0);
    chk("midrst_psum", psum_out, 0);
    chk("midrst_u_i", u_i_out, 0);
    chk("midrst_u_valid", u_i_valid_out, 0);
    chk("midrst_rand", w_rand_out, 0);
    i_valid = 1'b0;
    tick;
    resetn = 1'b1;
    set_rand;
    run_window(7'd100, 1'b0, 7'd50, 1'b0, 4, 16'd5, 16'd13, 1'b0, 0);
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) tick;
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
